// File: rtl/wb_cmd_initiator_if.sv
// Command/response and Wishbone classic signal bundle for wb_cmd_initiator.
// master = the initiator itself, slave = controller plus bus-slave side.
interface wb_cmd_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        cmd_we;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_dat_i;
  logic        wb_ack;

  modport master (
    input  cmd_valid, cmd_adr, cmd_dat, cmd_sel, cmd_we,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wb_adr, wb_dat_o, wb_sel, wb_we, wb_cyc, wb_stb,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    output cmd_valid, cmd_adr, cmd_dat, cmd_sel, cmd_we,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wb_adr, wb_dat_o, wb_sel, wb_we, wb_cyc, wb_stb,
    output wb_dat_i, wb_ack
  );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer initiator: one command -> one bus cycle.
// Define WB_TIMEOUT_EN to abort cycles lacking ACK after TIMEOUT_CYCLES.
module wb_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 i_clk,
  input logic                 i_reset,
  wb_cmd_initiator_if.master  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [31:0] r_wb_adr;
  logic [31:0] r_wb_dat;
  logic [3:0]  r_wb_sel;
  logic        r_wb_we;
  logic        r_wb_cyc;
  logic        r_wb_stb;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_cnt;
  logic        r_rsp_err;
  assign io_bus.rsp_err = r_rsp_err;
`else
  // Parameter kept referenced so both builds share one interface.
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign io_bus.rsp_err   = 1'b0;
`endif

  assign io_bus.cmd_ready = (r_state == S_IDLE) && !i_reset;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_dat   = r_rsp_dat;
  assign io_bus.wb_adr    = r_wb_adr;
  assign io_bus.wb_dat_o  = r_wb_dat;
  assign io_bus.wb_sel    = r_wb_sel;
  assign io_bus.wb_we     = r_wb_we;
  assign io_bus.wb_cyc    = r_wb_cyc;
  assign io_bus.wb_stb    = r_wb_stb;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_wb_adr    <= '0;
      r_wb_dat    <= '0;
      r_wb_sel    <= '0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_wb_stb    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
`ifdef WB_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (io_bus.cmd_valid) begin
            r_wb_adr <= io_bus.cmd_adr;
            r_wb_dat <= io_bus.cmd_dat;
            r_wb_sel <= io_bus.cmd_sel;
            r_wb_we  <= io_bus.cmd_we;
            r_wb_cyc <= 1'b1;
            r_wb_stb <= 1'b1;
            r_state  <= S_BUS;
`ifdef WB_TIMEOUT_EN
            r_cnt    <= '0;
`endif
          end
        end
        S_BUS: begin
          // ACK takes priority over a timeout expiring in the same cycle.
          if (io_bus.wb_ack) begin
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= r_wb_we ? '0 : io_bus.wb_dat_i;
            r_state     <= S_RESP;
`ifdef WB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
          end
`ifdef WB_TIMEOUT_EN
          else if (r_cnt == LP_LAST) begin
            r_wb_cyc    <= 1'b0;
            r_wb_stb    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (io_bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Self-checking bench for wb_cmd_initiator with a word-memory bus slave.
// Expected data comes from a byte-lane reference memory kept in the bench.
module tb_wb_cmd_initiator;

  localparam int TO = 16;
  localparam logic [31:0] LED = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cmd_initiator_if bus ();

  wb_cmd_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cycn   = 0;

  // Slave configuration and observations
  int          ack_delay = 0;
  logic        ack_en    = 1'b1;
  int          sc        = 0;
  int          stb_cnt   = 0;
  int          nocyc     = 0;
  logic [31:0] lg_adr, lg_dat;
  logic [3:0]  lg_sel;
  logic        lg_we;
  logic [31:0] slv_mem [16] = '{default: 32'h0};

  // Reference model
  logic [31:0] ref_mem [16] = '{default: 32'h0};

  int          acc_q[$];
  int          rc_q[$];
  logic [31:0] rd_q[$];
  logic        er_q[$];

  always @(posedge clk) cycn <= cycn + 1;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cycn);
      if (bus.rsp_valid && bus.rsp_ready) begin
        rd_q.push_back(bus.rsp_dat);
        er_q.push_back(bus.rsp_err);
        rc_q.push_back(cycn);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      bus.wb_ack   <= 1'b0;
      bus.wb_dat_i <= 32'h0;
      sc           <= 0;
    end else begin
      bus.wb_ack <= 1'b0;
      if (bus.wb_stb && !bus.wb_cyc) nocyc <= nocyc + 1;
      if (bus.wb_cyc && bus.wb_stb) begin
        stb_cnt <= stb_cnt + 1;
        if (!bus.wb_ack) begin
          if (ack_en && sc == ack_delay) begin
            bus.wb_ack <= 1'b1;
            sc         <= 0;
            lg_adr     <= bus.wb_adr;
            lg_dat     <= bus.wb_dat_o;
            lg_sel     <= bus.wb_sel;
            lg_we      <= bus.wb_we;
            if (bus.wb_we) begin
              slv_mem[bus.wb_adr[5:2]] <=
                (slv_mem[bus.wb_adr[5:2]] & ~{{8{bus.wb_sel[3]}},
                 {8{bus.wb_sel[2]}}, {8{bus.wb_sel[1]}}, {8{bus.wb_sel[0]}}})
                | (bus.wb_dat_o & {{8{bus.wb_sel[3]}}, {8{bus.wb_sel[2]}},
                 {8{bus.wb_sel[1]}}, {8{bus.wb_sel[0]}}});
              bus.wb_dat_i <= 32'hDEAD_BEEF;
            end else begin
              bus.wb_dat_i <= slv_mem[bus.wb_adr[5:2]];
            end
          end else begin
            sc <= sc + 1;
          end
        end
      end else begin
        sc <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic w,
                       output int acc);
    int n0;
    n0 = acc_q.size();
    bus.cmd_adr   = a;
    bus.cmd_dat   = d;
    bus.cmd_sel   = s;
    bus.cmd_we    = w;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200 && acc_q.size() == n0; i++) @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("accepted", 32'(acc_q.size() > n0), 32'd1);
    acc = (acc_q.size() > n0) ? acc_q[$] : -1000;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er,
                          output int rc, input int lim);
    int n0;
    n0 = rd_q.size();
    for (int i = 0; i < lim && rd_q.size() == n0; i++) @(negedge clk);
    chk("responded", 32'(rd_q.size() > n0), 32'd1);
    if (rd_q.size() > n0) begin
      rd = rd_q[$];
      er = er_q[$];
      rc = rc_q[$];
    end else begin
      rd = 32'hxxxx_xxxx;
      er = 1'bx;
      rc = -1000;
    end
  endtask

  // One full transfer with rsp_ready high, checked against the model.
  task automatic txn(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic w, input int dly);
    int          acc, rc, s0;
    logic [31:0] rd, exp;
    logic        er;
    ack_delay = dly;
    s0 = stb_cnt;
    exp = w ? 32'h0 : ref_mem[a[5:2]];
    issue(a, d, s, w, acc);
    wait_rsp(rd, er, rc, 200);
    chk("rsp_dat", rd, exp);
    chk("rsp_err", 32'(er), 32'd0);
    chk("latency", 32'(rc - acc), 32'(dly + 3));
    chk("stb_cycles", 32'(stb_cnt - s0), 32'(dly + 2));
    chk("bus_adr", lg_adr, a);
    chk("bus_we", 32'(lg_we), 32'(w));
    if (w) begin
      chk("bus_dat", lg_dat, d);
      chk("bus_sel", 32'(lg_sel), 32'(s));
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  initial begin
    int          acc, rc, a0, r0, n, cnt;
    logic [31:0] rd;
    logic        er;

    bus.cmd_valid = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_dat   = '0;
    bus.cmd_sel   = '0;
    bus.cmd_we    = 1'b0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("ready_in_reset", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb), 32'd0);
    chk("rst_we", 32'(bus.wb_we), 32'd0);
    chk("rst_adr", bus.wb_adr, 32'h0);
    chk("rst_dat", bus.wb_dat_o, 32'h0);
    chk("rst_sel", 32'(bus.wb_sel), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_dat", bus.rsp_dat, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);

    // LED write then read-back, single-cycle-ack slave
    txn(LED, 32'h0000_00A5, 4'hF, 1'b1, 0);
    chk("led_reg", slv_mem[0], 32'h0000_00A5);
    txn(LED, 32'h0, 4'hF, 1'b0, 0);

    // Back-to-back reads with valid held: one command per 4 cycles
    ack_delay = 0;
    a0 = acc_q.size();
    r0 = rd_q.size();
    bus.cmd_adr   = LED;
    bus.cmd_we    = 1'b0;
    bus.cmd_sel   = 4'hF;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100 && acc_q.size() < a0 + 4; i++) @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && rd_q.size() < r0 + 4; i++) @(negedge clk);
    chk("thru_accepts", 32'(acc_q.size() - a0), 32'd4);
    chk("thru_rsps", 32'(rd_q.size() - r0), 32'd4);
    if (acc_q.size() >= a0 + 4 && rd_q.size() >= r0 + 4)
      for (int k = 1; k < 4; k++) begin
        chk("thru_gap", 32'(acc_q[a0+k] - acc_q[a0+k-1]), 32'd4);
        chk("thru_dat", rd_q[r0+k], 32'h0000_00A5);
      end

    // Response backpressure for 10 cycles with a new command waiting
    bus.rsp_ready = 1'b0;
    ack_delay = 0;
    issue(LED, 32'h0, 4'hF, 1'b0, acc);
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) @(negedge clk);
    bus.cmd_adr   = LED + 32'd4;
    bus.cmd_dat   = 32'h1122_3344;
    bus.cmd_sel   = 4'hF;
    bus.cmd_we    = 1'b1;
    bus.cmd_valid = 1'b1;
    n = acc_q.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_dat", bus.rsp_dat, 32'h0000_00A5);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    chk("bp_no_accept", 32'(acc_q.size()), 32'(n));
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 50 && acc_q.size() == n; i++) @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("bp_accept_after", 32'(acc_q.size() - n), 32'd1);
    chk("bp_accept_gap", 32'(acc_q[$] - rc_q[$]), 32'd1);
    wait_rsp(rd, er, rc, 50);
    chk("bp_wr_dat", rd, 32'h0);
    for (int b = 0; b < 4; b++) ref_mem[1][8*b +: 8] = 8'h11 * (4 - b);

    // ACK landing in the timeout-expiry cycle still returns data
    txn(LED + 32'd4, 32'h0, 4'hF, 1'b0, TO - 2);

`ifdef WB_TIMEOUT_EN
    ack_en = 1'b0;
    n = stb_cnt;
    issue(LED, 32'h0, 4'hF, 1'b0, acc);
    wait_rsp(rd, er, rc, 100);
    chk("to_dat", rd, 32'h0);
    chk("to_err", 32'(er), 32'd1);
    chk("to_stb_cycles", 32'(stb_cnt - n), 32'(TO));
    chk("to_latency", 32'(rc - acc), 32'(TO + 1));
    ack_en = 1'b1;
`endif

    // Randomised transfers over four words
    for (int t = 0; t < 24; t++)
      txn(LED + 32'(4 * $urandom_range(0, 3)), $urandom,
          4'($urandom_range(1, 15)), 1'($urandom), $urandom_range(0, 4));

    // Reset while a cycle is outstanding with no ACK
    ack_en = 1'b0;
    issue(LED, 32'h0, 4'hF, 1'b0, acc);
`ifdef WB_TIMEOUT_EN
    repeat (3) @(negedge clk);
`else
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.wb_cyc && bus.wb_stb) cnt++;
    end
    chk("hang_cyc", 32'(cnt), 32'd1000);
`endif
    chk("pre_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    n = rd_q.size();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cyc", 32'(bus.wb_cyc), 32'd0);
    chk("mid_rst_stb", 32'(bus.wb_stb), 32'd0);
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (5) @(negedge clk);
    chk("post_rst_no_rsp", 32'(rd_q.size()), 32'(n));
    ack_en = 1'b1;
    txn(LED, 32'h0, 4'hF, 1'b0, 1);
    chk("stb_without_cyc", 32'(nocyc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
